// File: rtl/ieee754_argmax_stream_if.sv
// Valid/ready stream bundle for ieee754_argmax_stream: element input side and result output side.
// out_nan exists only when IEEE754_ARGMAX_NAN_SKIP_EN is defined.
interface ieee754_argmax_stream_if #(
    parameter int IDX_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_max;
    logic [IDX_W-1:0] out_idx;
    logic [IDX_W:0]   out_count;
    logic             out_err;
`ifdef IEEE754_ARGMAX_NAN_SKIP_EN
    logic             out_nan;
`endif

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_max, out_idx, out_count, out_err
`ifdef IEEE754_ARGMAX_NAN_SKIP_EN
      , input  out_nan
`endif
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_max, out_idx, out_count, out_err
`ifdef IEEE754_ARGMAX_NAN_SKIP_EN
      , output out_nan
`endif
    );
endinterface

// File: rtl/ieee754_argmax_stream.sv
// Streaming argmax over IEEE-754 single-precision vectors, one element per accepted beat.
// Optional NaN skipping is enabled by defining IEEE754_ARGMAX_NAN_SKIP_EN.
//
//   state | meaning
//   S_ACC | accepting elements, tracking best value/index
//   S_OUT | result presented, waiting for out_ready
module ieee754_argmax_stream #(
    parameter int N_MAX = 16,
    parameter int IDX_W = 4
) (
    input logic                    clk,
    input logic                    rst_n,
    ieee754_argmax_stream_if.slave bus
);
    typedef enum logic {S_ACC, S_OUT} state_t;

    localparam logic [IDX_W:0] CNT_MAX = (IDX_W+1)'(N_MAX);
    localparam logic [IDX_W:0] CNT_ONE = (IDX_W+1)'(1);

    state_t           state_q, state_d;
    logic [IDX_W:0]   cnt_q, cnt_d;
    logic [31:0]      best_q, best_d;
    logic [IDX_W-1:0] best_idx_q, best_idx_d;
    logic             err_q, err_d;
    logic [31:0]      out_max_q, out_max_d;
    logic [IDX_W-1:0] out_idx_q, out_idx_d;
    logic [IDX_W:0]   out_count_q, out_count_d;
    logic             out_err_q, out_err_d;
`ifdef IEEE754_ARGMAX_NAN_SKIP_EN
    logic             nan_q, nan_d;
    logic             have_q, have_d;
    logic             out_nan_q, out_nan_d;
    logic             in_is_nan;
    assign in_is_nan = (bus.in_data[30:23] == 8'hFF) && (bus.in_data[22:0] != 23'd0);
`endif

    // Strict sign-magnitude ordering; +0 and -0 compare equal.
    function automatic logic fp_gt(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 && b[30:0] == 31'd0) return 1'b0;
        if (a[31] != b[31])                       return ~a[31];
        if (!a[31])                               return a[30:0] > b[30:0];
        return a[30:0] < b[30:0];
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        best_d      = best_q;
        best_idx_d  = best_idx_q;
        err_d       = err_q;
        out_max_d   = out_max_q;
        out_idx_d   = out_idx_q;
        out_count_d = out_count_q;
        out_err_d   = out_err_q;
`ifdef IEEE754_ARGMAX_NAN_SKIP_EN
        nan_d       = nan_q;
        have_d      = have_q;
        out_nan_d   = out_nan_q;
`endif
        case (state_q)
            S_ACC: begin
                if (bus.in_valid) begin
                    if (cnt_q == CNT_MAX) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
`ifdef IEEE754_ARGMAX_NAN_SKIP_EN
                        if (in_is_nan) begin
                            nan_d = 1'b1;
                        end else if (!have_q || fp_gt(bus.in_data, best_q)) begin
                            best_d     = bus.in_data;
                            best_idx_d = cnt_q[IDX_W-1:0];
                            have_d     = 1'b1;
                        end
`else
                        if (cnt_q == '0 || fp_gt(bus.in_data, best_q)) begin
                            best_d     = bus.in_data;
                            best_idx_d = cnt_q[IDX_W-1:0];
                        end
`endif
                    end
                    // Result includes this beat's compare, so load from the _d values.
                    if (bus.in_last) begin
                        state_d     = S_OUT;
                        out_max_d   = best_d;
                        out_idx_d   = best_idx_d;
                        out_count_d = cnt_d;
                        out_err_d   = err_d;
`ifdef IEEE754_ARGMAX_NAN_SKIP_EN
                        out_nan_d   = nan_d;
                        if (!have_d) begin
                            out_max_d = 32'h7FC0_0000;
                            out_idx_d = '0;
                        end
`endif
                    end
                end
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    state_d = S_ACC;
                    cnt_d   = '0;
                    err_d   = 1'b0;
`ifdef IEEE754_ARGMAX_NAN_SKIP_EN
                    nan_d     = 1'b0;
                    have_d    = 1'b0;
                    out_nan_d = 1'b0;
`endif
                end
            end
            default: state_d = S_ACC;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_ACC;
            cnt_q       <= '0;
            best_q      <= 32'h0;
            best_idx_q  <= '0;
            err_q       <= 1'b0;
            out_max_q   <= 32'h0;
            out_idx_q   <= '0;
            out_count_q <= '0;
            out_err_q   <= 1'b0;
`ifdef IEEE754_ARGMAX_NAN_SKIP_EN
            nan_q       <= 1'b0;
            have_q      <= 1'b0;
            out_nan_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            best_q      <= best_d;
            best_idx_q  <= best_idx_d;
            err_q       <= err_d;
            out_max_q   <= out_max_d;
            out_idx_q   <= out_idx_d;
            out_count_q <= out_count_d;
            out_err_q   <= out_err_d;
`ifdef IEEE754_ARGMAX_NAN_SKIP_EN
            nan_q       <= nan_d;
            have_q      <= have_d;
            out_nan_q   <= out_nan_d;
`endif
        end
    end

    assign bus.in_ready  = (state_q == S_ACC);
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_max   = out_max_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_count = out_count_q;
    assign bus.out_err   = out_err_q;
`ifdef IEEE754_ARGMAX_NAN_SKIP_EN
    assign bus.out_nan   = out_nan_q;
`endif
endmodule

// File: tb/tb_ieee754_argmax_stream.sv
// Directed bench for ieee754_argmax_stream: hand-computed argmax results, backpressure,
// overflow past N_MAX and mid-vector reset.
module tb_ieee754_argmax_stream;
    localparam int N_MAX = 16;
    localparam int IDX_W = 4;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    logic [31:0] vq[$];

    ieee754_argmax_stream_if #(.IDX_W(IDX_W)) bus ();

    ieee754_argmax_stream #(.N_MAX(N_MAX), .IDX_W(IDX_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // Drive one beat at a negedge and hold it until a cycle where in_ready is high.
    task automatic send_beat(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 32'(bus.in_ready), 32'd1);
        if (last) chk("no_early_valid", 32'(bus.out_valid), 32'd0);
    endtask

    task automatic send_vec();
        for (int i = 0; i < vq.size(); i++)
            send_beat(vq[i], (i == vq.size() - 1));
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_res(input string tag, input logic [31:0] mx, input int idx,
                             input int cnt, input logic err);
        chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_ready"}, 32'(bus.in_ready), 32'd0);
        chk({tag, "_max"},   bus.out_max, mx);
        chk({tag, "_idx"},   32'(bus.out_idx), 32'(idx));
        chk({tag, "_count"}, 32'(bus.out_count), 32'(cnt));
        chk({tag, "_err"},   32'(bus.out_err), 32'(err));
    endtask

    task automatic check_release(input string tag, input logic [31:0] mx);
        @(negedge clk);
        chk({tag, "_rel_valid"}, 32'(bus.out_valid), 32'd0);
        chk({tag, "_rel_ready"}, 32'(bus.in_ready), 32'd1);
        chk({tag, "_rel_hold"},  bus.out_max, mx);
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        chk("rst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_max",   bus.out_max, 32'h0);
        chk("rst_out_idx",   32'(bus.out_idx), 32'd0);
        chk("rst_out_count", 32'(bus.out_count), 32'd0);
        chk("rst_out_err",   32'(bus.out_err), 32'd0);

        vq = '{32'h4040_0000, 32'h4048_0000, 32'h3F80_0000};
        send_vec();
        check_res("pos", 32'h4048_0000, 1, 3, 1'b0);
        check_release("pos", 32'h4048_0000);

        vq = '{32'hC048_0000, 32'hC040_0000, 32'hC080_0000};
        send_vec();
        check_res("neg", 32'hC040_0000, 1, 3, 1'b0);
        check_release("neg", 32'hC040_0000);

        vq = '{32'h8000_0000, 32'h0000_0000, 32'h4040_0000, 32'h4040_0000};
        send_vec();
        check_res("tie", 32'h4040_0000, 2, 4, 1'b0);
        check_release("tie", 32'h4040_0000);

        vq = '{32'h8000_0000, 32'h0000_0000};
        send_vec();
        check_res("zeros", 32'h8000_0000, 0, 2, 1'b0);
        check_release("zeros", 32'h8000_0000);

        bus.out_ready = 1'b0;
        vq = '{32'h3F80_0000, 32'hBF80_0000};
        send_vec();
        check_res("bp", 32'h3F80_0000, 0, 2, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 32'h7F00_0000;
            bus.in_last  = 1'b1;
            @(negedge clk);
            chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
            chk("bp_hold_max",   bus.out_max, 32'h3F80_0000);
            chk("bp_hold_count", 32'(bus.out_count), 32'd2);
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        check_release("bp", 32'h3F80_0000);

        vq = '{32'h0000_0001, 32'h0000_0002, 32'h0000_0001};
        send_vec();
        check_res("post_bp", 32'h0000_0002, 1, 3, 1'b0);
        check_release("post_bp", 32'h0000_0002);

        vq = {};
        for (int i = 0; i < 18; i++) vq.push_back(32'h3F80_0000);
        vq[5]  = 32'h4100_0000;
        vq[17] = 32'h7F00_0000;
        send_vec();
        check_res("ovf", 32'h4100_0000, 5, 16, 1'b1);
        check_release("ovf", 32'h4100_0000);

        vq = '{32'hC120_0000};
        send_vec();
        check_res("single", 32'hC120_0000, 0, 1, 1'b0);
        check_release("single", 32'hC120_0000);

        send_beat(32'h3F80_0000, 1'b0);
        send_beat(32'h4000_0000, 1'b0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n        = 1'b0;
        #1;
        chk("mrst_in_ready",  32'(bus.in_ready), 32'd1);
        chk("mrst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mrst_out_max",   bus.out_max, 32'h0);
        chk("mrst_out_count", 32'(bus.out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        vq = '{32'hBF80_0000, 32'h3F00_0000, 32'h3F80_0000};
        send_vec();
        check_res("after_rst", 32'h3F80_0000, 2, 3, 1'b0);
        check_release("after_rst", 32'h3F80_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end
endmodule

// File: doc/ieee754_argmax_stream.md
Name: ieee754_argmax_stream

Overview:
Streaming reduction unit that consumes a vector of IEEE-754 single-precision values, one per accepted beat, and returns the maximum value and its index. It uses the same ordering rules as the combinational float comparator, applied sequentially across a vector. It sits after the output layer or score accumulator of the inference/training datapath, for class selection. Valid/ready handshake on both sides; one vector in flight at a time.

Parameters:
N_MAX, 16, maximum vector length in elements.
IDX_W, 4, index width; must satisfy 2**IDX_W >= N_MAX.

Ports:
clk  input  1  system clock, rising-edge.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data/in_last valid this cycle.
in_ready  output  1  block accepts a beat this cycle.
in_data  input  32  IEEE-754 single-precision element.
in_last  input  1  marks final element of the vector.
out_valid  output  1  result valid; held until accepted.
out_ready  input  1  downstream accepts the result.
out_max  output  32  maximum element, raw bits.
out_idx  output  IDX_W  zero-based index of the maximum.
out_count  output  IDX_W+1  number of elements compared, saturates at N_MAX.
out_err  output  1  vector exceeded N_MAX elements.

Behaviour:
- Clock and reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset values: state=S_ACC, in_ready=1, out_valid=0, out_max=32'h0, out_idx=0, out_count=0, out_err=0, internal cnt=0. Reset mid-vector or mid-output discards all progress; there is no partial result.
- States:
  - S_ACC: in_ready=1, out_valid=0.
  - S_OUT: in_ready=0, out_valid=1, all outputs stable.
- Beat accepted when in_valid && in_ready.
- Compare rule, "A greater than B", strict:
  - Signs differ: positive wins.
  - Both positive: larger {exp,mant} wins.
  - Both negative: smaller {exp,mant} wins.
  - Identical bits: not greater.
  - +0 and -0 are equal (not greater).
  - NaN/Inf: no special handling; ordered by the rules above, except NaN handling under the optional feature.
- First accepted element (cnt==0): best=in_data, best_idx=0 unconditionally.
- Later elements with cnt<N_MAX: update best/best_idx=cnt only if in_data is strictly greater. Ties keep the earliest index.
- cnt increments per accepted beat while cnt<N_MAX.
- Accepted beat with cnt==N_MAX: element is discarded (not compared), cnt holds, err flag set.
- in_last accepted: next cycle state=S_OUT and out_valid=1. Latency is 1 cycle from the last accepted beat to out_valid. Outputs are registered from best/best_idx/cnt/err, including the final element's compare.
- A single-element vector (first beat has in_last=1) gives out_idx=0, out_count=1.
- S_OUT, out_valid && out_ready: next cycle returns to S_ACC with cnt=0 and err=0; out_valid deasserts. out_max, out_idx and out_count hold their last values until the next result.
- out_ready held high before out_valid: result is consumed in the first S_OUT cycle, so the minimum vector period is N+1 cycles.
- in_valid while in S_OUT: ignored (not accepted); upstream must hold the beat.
- out_count width IDX_W+1 so that N_MAX is representable.

Optional Feature:
Macro IEEE754_ARGMAX_NAN_SKIP_EN.
- Defined:
  - Elements with exp==8'hFF and mant!=0 are not compared but still consume an index (cnt increments).
  - Extra output out_nan (1 bit, reset 0) is set if any NaN was seen in the vector; it is cleared with err on the output handshake.
  - If the first element is NaN, the next non-NaN element is loaded unconditionally.
  - If all elements are NaN: out_max=32'h7FC00000, out_idx=0.
- Not defined: no out_nan port; NaN is ordered by raw sign-magnitude like any other value.

Test Plan:
- Vector {40400000 (3.0), 40480000 (3.125), 3F800000 (1.0)}, last on beat 3, out_ready=1 -> out_valid one cycle after last; out_max=40480000, out_idx=1, out_count=3, out_err=0.
- All-negative {C0480000, C0400000, C0800000} -> out_max=C0400000 (-3.0), out_idx=1.
- Ties and zeros {80000000 (-0), 00000000 (+0), 40400000, 40400000} -> out_max=40400000, out_idx=2 (earliest tie kept); then the vector {80000000, 00000000} -> out_idx=0.
- Backpressure: out_ready=0 for 5 cycles after result -> out_valid and outputs stable, in_ready=0, in_valid beats not accepted; out_ready=1 -> next cycle in_ready=1, the following vector is processed correctly.
- Overflow: 18 beats with N_MAX=16, max value at index 17 -> out_err=1, out_count=16, out_idx from the first 16 elements only.
- Reset: assert rst_n=0 after 2 beats of a vector -> all outputs return to reset values immediately; a fresh 3-element vector then gives out_count=3 and the correct index.
